// File: rtl/d_ctrl_fwd_cmp.sv
// Decode-stage control: instruction decode, operand forwarding, branch compare,
// and the D/E pipeline registers.
module d_ctrl_fwd_cmp (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ClearE,
    input  logic [31:0] IRD,
    input  logic [31:0] RS_D,
    input  logic [31:0] RT_D,
    input  logic [2:0]  Forward_RS_D_src,
    input  logic [2:0]  Forward_RT_D_src,
    input  logic [31:0] PC4_forw_E,
    input  logic [31:0] PC4_forw_M,
    input  logic [31:0] AO,
    input  logic [31:0] W_RF_WD_OUT,
    output logic [1:0]  EXTop,
    output logic [2:0]  PCsrc,
    output logic        NPCsrc,
    output logic        Branch,
    output logic [31:0] RS_D_F,
    output logic [31:0] RT_D_F,
    output logic [31:0] IRE,
    output logic [31:0] RSE,
    output logic [31:0] RTE
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    logic [5:0]  op;
    logic [4:0]  rt;
    logic [5:0]  fn;
    logic        is_bltz;
    logic        is_bgez;
    logic        rs_neg;
    logic        rs_zero;

    assign op = IRD[31:26];
    assign rt = IRD[20:16];
    assign fn = IRD[5:0];

    assign is_bltz = (op == OP_REGIMM) && (rt == 5'd0);
    assign is_bgez = (op == OP_REGIMM) && (rt == 5'd1);

    // PC4 sources carry the address of the following instruction; +4 wraps at 32 bits.
    function automatic logic [31:0] fwd_sel(
        input logic [2:0]  sel,
        input logic [31:0] reg_val,
        input logic [31:0] pc4_e,
        input logic [31:0] ao_val,
        input logic [31:0] pc4_m,
        input logic [31:0] wb_val
    );
        logic [31:0] res;
        case (sel)
            3'd1:    res = pc4_e + 32'd4;
            3'd2:    res = ao_val;
            3'd3:    res = pc4_m + 32'd4;
            3'd4:    res = wb_val;
            default: res = reg_val;
        endcase
        return res;
    endfunction

    always_comb begin
        RS_D_F = fwd_sel(Forward_RS_D_src, RS_D, PC4_forw_E, AO, PC4_forw_M, W_RF_WD_OUT);
        RT_D_F = fwd_sel(Forward_RT_D_src, RT_D, PC4_forw_E, AO, PC4_forw_M, W_RF_WD_OUT);
    end

    always_comb begin
        EXTop = 2'd0;
        case (op)
            6'h0F: EXTop = 2'd2;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2B,
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: EXTop = 2'd1;
            OP_REGIMM: if (is_bltz || is_bgez) EXTop = 2'd1;
            default: EXTop = 2'd0;
        endcase
    end

    always_comb begin
        PCsrc  = 3'd0;
        NPCsrc = 1'b0;
        case (op)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: PCsrc = 3'd1;
            OP_REGIMM: if (is_bltz || is_bgez) PCsrc = 3'd1;
            OP_J, OP_JAL: begin
                PCsrc  = 3'd2;
                NPCsrc = 1'b1;
            end
            OP_SPECIAL: if (fn == FN_JR || fn == FN_JALR) PCsrc = 3'd3;
            default: PCsrc = 3'd0;
        endcase
    end

    assign rs_neg  = RS_D_F[31];
    assign rs_zero = (RS_D_F == 32'd0);

    always_comb begin
        Branch = 1'b0;
        case (op)
            OP_BEQ:    Branch = (RS_D_F == RT_D_F);
            OP_BNE:    Branch = (RS_D_F != RT_D_F);
            OP_BLEZ:   Branch = rs_neg || rs_zero;
            OP_BGTZ:   Branch = !rs_neg && !rs_zero;
            OP_REGIMM: begin
                if (is_bltz)      Branch = rs_neg;
                else if (is_bgez) Branch = !rs_neg;
            end
            default:   Branch = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            IRE <= 32'd0;
            RSE <= 32'd0;
            RTE <= 32'd0;
        end else if (ClearE) begin
            IRE <= 32'd0;
            RSE <= 32'd0;
            RTE <= 32'd0;
        end else begin
            IRE <= IRD;
            RSE <= RS_D_F;
            RTE <= RT_D_F;
        end
    end

endmodule

// File: tb/tb_d_ctrl_fwd_cmp.sv
// Directed bench for d_ctrl_fwd_cmp: decode, forwarding, branch compare,
// D/E registers and async reset.
module tb_d_ctrl_fwd_cmp;

    logic        Clk;
    logic        Reset;
    logic        ClearE;
    logic [31:0] IRD;
    logic [31:0] RS_D;
    logic [31:0] RT_D;
    logic [2:0]  Forward_RS_D_src;
    logic [2:0]  Forward_RT_D_src;
    logic [31:0] PC4_forw_E;
    logic [31:0] PC4_forw_M;
    logic [31:0] AO;
    logic [31:0] W_RF_WD_OUT;
    logic [1:0]  EXTop;
    logic [2:0]  PCsrc;
    logic        NPCsrc;
    logic        Branch;
    logic [31:0] RS_D_F;
    logic [31:0] RT_D_F;
    logic [31:0] IRE;
    logic [31:0] RSE;
    logic [31:0] RTE;

    int checks   = 0;
    int failures = 0;

    d_ctrl_fwd_cmp dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .ClearE           (ClearE),
        .IRD              (IRD),
        .RS_D             (RS_D),
        .RT_D             (RT_D),
        .Forward_RS_D_src (Forward_RS_D_src),
        .Forward_RT_D_src (Forward_RT_D_src),
        .PC4_forw_E       (PC4_forw_E),
        .PC4_forw_M       (PC4_forw_M),
        .AO               (AO),
        .W_RF_WD_OUT      (W_RF_WD_OUT),
        .EXTop            (EXTop),
        .PCsrc            (PCsrc),
        .NPCsrc           (NPCsrc),
        .Branch           (Branch),
        .RS_D_F           (RS_D_F),
        .RT_D_F           (RT_D_F),
        .IRE              (IRE),
        .RSE              (RSE),
        .RTE              (RTE)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b0;
        ClearE = 1'b0;
        IRD = 32'h0;
        RS_D = 32'h0;
        RT_D = 32'h0;
        Forward_RS_D_src = 3'd0;
        Forward_RT_D_src = 3'd0;
        PC4_forw_E = 32'h0;
        PC4_forw_M = 32'h0;
        AO = 32'h0;
        W_RF_WD_OUT = 32'h0;

        #2;
        chk("rst_ire", IRE, 32'h0);
        chk("rst_rse", RSE, 32'h0);
        chk("rst_rte", RTE, 32'h0);

        // Combinational paths stay live while in reset
        IRD = 32'h10430003; RS_D = 32'd5; RT_D = 32'd5;
        #1;
        chk("rst_comb_branch", {31'd0, Branch}, 32'd1);
        chk("rst_comb_rsf", RS_D_F, 32'd5);

        @(negedge Clk);
        Reset = 1'b1;

        // beq
        IRD = 32'h10430003; RS_D = 32'd5; RT_D = 32'd5;
        #1;
        chk("beq_eq_branch", {31'd0, Branch}, 32'd1);
        chk("beq_pcsrc", {29'd0, PCsrc}, 32'd1);
        chk("beq_extop", {30'd0, EXTop}, 32'd1);
        chk("beq_npcsrc", {31'd0, NPCsrc}, 32'd0);
        RT_D = 32'd6; #1;
        chk("beq_ne_branch", {31'd0, Branch}, 32'd0);

        // bne
        IRD = 32'h14430003; #1;
        chk("bne_ne_branch", {31'd0, Branch}, 32'd1);
        RT_D = 32'd5; #1;
        chk("bne_eq_branch", {31'd0, Branch}, 32'd0);

        // Forwarding selects
        RS_D = 32'd1; AO = 32'h22; PC4_forw_E = 32'h3000;
        PC4_forw_M = 32'hFFFF_FFFC; W_RF_WD_OUT = 32'hABCD_1234;
        Forward_RS_D_src = 3'd1; #1;
        chk("fwd_rs_1", RS_D_F, 32'h3004);
        Forward_RS_D_src = 3'd2; #1;
        chk("fwd_rs_2", RS_D_F, 32'h22);
        Forward_RS_D_src = 3'd6; #1;
        chk("fwd_rs_6", RS_D_F, 32'd1);
        Forward_RS_D_src = 3'd3; #1;
        chk("fwd_rs_3_wrap", RS_D_F, 32'h0);
        Forward_RS_D_src = 3'd4; #1;
        chk("fwd_rs_4", RS_D_F, 32'hABCD_1234);
        Forward_RS_D_src = 3'd7; #1;
        chk("fwd_rs_7", RS_D_F, 32'd1);
        RT_D = 32'd9;
        Forward_RT_D_src = 3'd1; #1;
        chk("fwd_rt_1", RT_D_F, 32'h3004);
        Forward_RT_D_src = 3'd4; #1;
        chk("fwd_rt_4", RT_D_F, 32'hABCD_1234);
        Forward_RT_D_src = 3'd5; #1;
        chk("fwd_rt_5", RT_D_F, 32'd9);

        // beq using forwarded values on both sides
        IRD = 32'h10430003; Forward_RS_D_src = 3'd2; Forward_RT_D_src = 3'd2; #1;
        chk("beq_fwd_branch", {31'd0, Branch}, 32'd1);
        Forward_RT_D_src = 3'd0; RT_D = 32'd0; #1;

        // Signed relational compares on forwarded RS (AO via select 2)
        IRD = 32'h1C200004; AO = 32'h8000_0000; #1;
        chk("bgtz_neg", {31'd0, Branch}, 32'd0);
        AO = 32'h1; #1;
        chk("bgtz_pos", {31'd0, Branch}, 32'd1);
        AO = 32'h0; #1;
        chk("bgtz_zero", {31'd0, Branch}, 32'd0);
        IRD = 32'h18200004; #1;
        chk("blez_zero", {31'd0, Branch}, 32'd1);
        AO = 32'h7FFF_FFFF; #1;
        chk("blez_maxpos", {31'd0, Branch}, 32'd0);
        IRD = 32'h04210004; AO = 32'h0; #1;
        chk("bgez_zero", {31'd0, Branch}, 32'd1);
        chk("bgez_pcsrc", {29'd0, PCsrc}, 32'd1);
        AO = 32'hFFFF_FFFF; #1;
        chk("bgez_neg", {31'd0, Branch}, 32'd0);
        IRD = 32'h04200004; #1;
        chk("bltz_neg", {31'd0, Branch}, 32'd1);
        AO = 32'h0; #1;
        chk("bltz_zero", {31'd0, Branch}, 32'd0);
        IRD = 32'h04220004; AO = 32'hFFFF_FFFF; #1;
        chk("regimm_rt2_branch", {31'd0, Branch}, 32'd0);
        chk("regimm_rt2_pcsrc", {29'd0, PCsrc}, 32'd0);
        Forward_RS_D_src = 3'd0;

        // Decode
        IRD = 32'h3C010001; #1;
        chk("lui_extop", {30'd0, EXTop}, 32'd2);
        IRD = 32'h0C000010; #1;
        chk("jal_pcsrc", {29'd0, PCsrc}, 32'd2);
        chk("jal_npcsrc", {31'd0, NPCsrc}, 32'd1);
        IRD = 32'h08000010; #1;
        chk("j_npcsrc", {31'd0, NPCsrc}, 32'd1);
        IRD = 32'h03E00008; #1;
        chk("jr_pcsrc", {29'd0, PCsrc}, 32'd3);
        chk("jr_npcsrc", {31'd0, NPCsrc}, 32'd0);
        IRD = 32'h03E0F809; #1;
        chk("jalr_pcsrc", {29'd0, PCsrc}, 32'd3);
        RS_D = 32'd4; RT_D = 32'd4;
        IRD = 32'h00430821; #1;
        chk("addu_pcsrc", {29'd0, PCsrc}, 32'd0);
        chk("addu_branch", {31'd0, Branch}, 32'd0);
        IRD = 32'h34210001; #1;
        chk("ori_extop", {30'd0, EXTop}, 32'd0);
        IRD = 32'h8C220000; #1;
        chk("lw_extop", {30'd0, EXTop}, 32'd1);
        IRD = 32'h24220005; #1;
        chk("addiu_extop", {30'd0, EXTop}, 32'd1);
        IRD = 32'h10430003; #1;
        chk("beq_same_branch", {31'd0, Branch}, 32'd1);

        // D/E pipeline registers
        IRD = 32'h34210001; RS_D = 32'd7; RT_D = 32'd9;
        @(posedge Clk); #1;
        chk("pipe_ire", IRE, 32'h34210001);
        chk("pipe_rse", RSE, 32'd7);
        chk("pipe_rte", RTE, 32'd9);
        ClearE = 1'b1;
        @(posedge Clk); #1;
        chk("clr_ire", IRE, 32'h0);
        chk("clr_rse", RSE, 32'h0);
        chk("clr_rte", RTE, 32'h0);
        ClearE = 1'b0; AO = 32'h55; Forward_RT_D_src = 3'd2;
        @(posedge Clk); #1;
        chk("reload_ire", IRE, 32'h34210001);
        chk("reload_rte_fwd", RTE, 32'h55);

        // Async reset mid-cycle
        #2;
        Reset = 1'b0;
        #1;
        chk("async_ire", IRE, 32'h0);
        chk("async_rse", RSE, 32'h0);
        chk("async_rte", RTE, 32'h0);
        @(posedge Clk); #1;
        chk("hold_ire", IRE, 32'h0);
        chk("hold_rse", RSE, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk("post_rst_ire", IRE, 32'h34210001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/d_ctrl_fwd_cmp.md
D_CTRL_FWD_CMP -- requirements
Module: d_ctrl_fwd_cmp

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all registers update on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port ClearE, input, 1 bit: synchronous flush of the D/E registers.
REQ-004 SHALL have port IRD, input, 32 bits: instruction in the decode stage.
REQ-005 SHALL have ports RS_D and RT_D, input, 32 bits each: register-file read data for IRD[25:21] and IRD[20:16].
REQ-006 SHALL have ports Forward_RS_D_src and Forward_RT_D_src, input, 3 bits each: forwarding selects.
REQ-007 SHALL have ports PC4_forw_E, PC4_forw_M, AO and W_RF_WD_OUT, input, 32 bits each: forwarding sources.
REQ-008 SHALL have ports EXTop (2 bits), PCsrc (3 bits), NPCsrc (1 bit) and Branch (1 bit), all outputs: decode and compare results.
REQ-009 SHALL have ports RS_D_F and RT_D_F, output, 32 bits each: forwarded operands.
REQ-010 SHALL have ports IRE, RSE and RTE, output, 32 bits each: D/E pipeline registers.

Function (op = IRD[31:26], rt = IRD[20:16], fn = IRD[5:0])
REQ-011 SHALL set EXTop = 0 (zero-extend) for ori 0x0D, andi 0x0C and xori 0x0E.
REQ-012 SHALL set EXTop = 2 (imm<<16) for lui 0x0F.
REQ-013 SHALL set EXTop = 1 (sign-extend) for addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B, loads 0x20/21/23/24/25, stores 0x28/29/2B, and branches.
REQ-014 SHALL set EXTop = 0 for all other encodings.
REQ-015 SHALL set PCsrc = 0 (sequential) by default.
REQ-016 SHALL set PCsrc = 1 for conditional branches: beq 0x04, bne 0x05, blez 0x06, bgtz 0x07, and REGIMM 0x01 with rt=0 (bltz) or rt=1 (bgez).
REQ-017 SHALL set PCsrc = 2 for j 0x02 and jal 0x03.
REQ-018 SHALL set PCsrc = 3 for op 0x00 with fn 0x08 (jr) or fn 0x09 (jalr).
REQ-019 SHALL never produce PCsrc values 4-7.
REQ-020 SHALL set NPCsrc = 1 for j/jal (26-bit index) and NPCsrc = 0 otherwise (16-bit branch offset).
REQ-021 SHALL form the forwarded RS value from Forward_RS_D_src as: 0 RS_D; 1 PC4_forw_E+4; 2 AO; 3 PC4_forw_M+4; 4 W_RF_WD_OUT; 5-7 RS_D.
REQ-022 SHALL form the forwarded RT value identically from Forward_RT_D_src and RT_D.
REQ-023 SHALL compute PC4+4 as a 32-bit add that wraps on overflow.
REQ-024 SHALL drive RS_D_F and RT_D_F combinationally with the forwarded values.
REQ-025 SHALL compute Branch combinationally from the forwarded values; relational compares are signed two's-complement on RS:
- beq: RS==RT
- bne: RS!=RT
- blez: RS<=0
- bgtz: RS>0
- bltz: RS<0
- bgez: RS>=0
REQ-026 SHALL hold Branch = 0 for every non-branch instruction, including REGIMM with rt not 0/1.
REQ-027 SHALL, on each rising Clk edge with Reset high: if ClearE=1 load IRE, RSE and RTE with 0; otherwise load IRD, the forwarded RS and the forwarded RT.
REQ-028 SHALL have no other state; all decode, forwarding and compare paths have zero-cycle latency.

Reset
REQ-029 SHALL force IRE, RSE and RTE to 0 immediately when Reset=0, independent of Clk, and hold them at 0 while Reset stays low.
REQ-030 SHALL keep combinational outputs functional during reset.
REQ-031 SHALL give Reset priority over ClearE.

Verification
REQ-032 SHALL cover beq: IRD=0x10430003, RS_D=RT_D=5, both selects 0 -> Branch=1, PCsrc=1, EXTop=1, NPCsrc=0; then RT_D=6 -> Branch=0.
REQ-033 SHALL cover forwarding priority: RS_D=1, AO=0x22, PC4_forw_E=0x3000, select 1 -> RS_D_F=0x3004; select 2 -> 0x22; select 6 -> 1.
REQ-034 SHALL cover signed compare: bgtz with forwarded RS=0x80000000 -> Branch=0; bgez with RS=0 -> Branch=1.
REQ-035 SHALL cover decode: lui -> EXTop=2; jal -> PCsrc=2, NPCsrc=1; jr (op 0, fn 0x08) -> PCsrc=3; addu -> PCsrc=0, Branch=0.
REQ-036 SHALL cover pipeline registers: IRD=0x34210001, RS_D=7, clock edge -> IRE=0x34210001, RSE=7; ClearE=1, edge -> all 0.
REQ-037 SHALL cover async reset: drive Reset low mid-cycle with registers nonzero -> IRE/RSE/RTE read 0 before the next Clk edge.
